// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide data memory; sub-word stores run as read-modify-write.
// Optional: define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module load_store_unit #(
  parameter int MEM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        data_memory_write_enable,
  output logic [31:0] data_memory_access_address,
  output logic [31:0] data_memory_write_data,
  input  logic [31:0] data_memory_read_data
);

  typedef enum logic [2:0] {IDLE, ACCESS, RMW_READ, RMW_WRITE, RESP} state_t;

  localparam logic [31:0] MEM_WORDS_W = 32'(MEM_WORDS);

  state_t      state, state_next;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_lane;
  logic [31:0] lat_wdata;
  logic [31:0] merge_word;
  logic [31:0] merged_word;
  logic [31:0] load_data;
  logic [1:0]  req_lane;
  logic        req_error;

  // Decode the incoming request: lane after alignment and whether it must be rejected
  always_comb begin
    case (req_size)
      2'b01:   req_lane = {req_addr[1], 1'b0};
      2'b10:   req_lane = 2'b00;
      default: req_lane = req_addr[1:0];
    endcase
    req_error = (req_size == 2'b11) || ({2'b00, req_addr[31:2]} >= MEM_WORDS_W);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((req_size == 2'b01 && req_addr[0]) || (req_size == 2'b10 && req_addr[1:0] != 2'b00))
      req_error = 1'b1;
`endif
  end

  always_comb begin
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    case (lat_lane)
      2'b00:   lane_byte = data_memory_read_data[7:0];
      2'b01:   lane_byte = data_memory_read_data[15:8];
      2'b10:   lane_byte = data_memory_read_data[23:16];
      default: lane_byte = data_memory_read_data[31:24];
    endcase
    lane_half = lat_lane[1] ? data_memory_read_data[31:16] : data_memory_read_data[15:0];
    case (lat_size)
      2'b00:   load_data = {{24{~lat_unsigned & lane_byte[7]}}, lane_byte};
      2'b01:   load_data = {{16{~lat_unsigned & lane_half[15]}}, lane_half};
      default: load_data = data_memory_read_data;
    endcase
  end

  always_comb begin
    merged_word = merge_word;
    if (lat_size == 2'b00)
      merged_word[{lat_lane, 3'b000} +: 8] = lat_wdata[7:0];
    else if (lat_lane[1])
      merged_word[31:16] = lat_wdata[15:0];
    else
      merged_word[15:0] = lat_wdata[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Write enable is only raised in states that do not sample read data
  always_comb begin
    state_next               = state;
    req_ready                = 1'b0;
    data_memory_write_enable = 1'b0;
    data_memory_write_data   = 32'h0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_error)                          state_next = RESP;
          else if (req_write && req_size != 2'b10) state_next = RMW_READ;
          else                                    state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (lat_write) begin
          data_memory_write_enable = 1'b1;
          data_memory_write_data   = lat_wdata;
        end
        state_next = RESP;
      end
      RMW_READ:  state_next = RMW_WRITE;
      RMW_WRITE: begin
        data_memory_write_enable = 1'b1;
        data_memory_write_data   = merged_word;
        state_next               = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);

  // Request latch, memory address hold, load capture and RMW merge capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write                  <= 1'b0;
      lat_size                   <= 2'b00;
      lat_unsigned               <= 1'b0;
      lat_lane                   <= 2'b00;
      lat_wdata                  <= 32'h0;
      merge_word                 <= 32'h0;
      resp_rdata                 <= 32'h0;
      resp_error                 <= 1'b0;
      data_memory_access_address <= 32'h0;
    end else begin
      if (state == IDLE && req_valid) begin
        lat_write    <= req_write;
        lat_size     <= req_size;
        lat_unsigned <= req_unsigned;
        lat_lane     <= req_lane;
        lat_wdata    <= req_wdata;
        resp_rdata   <= 32'h0;
        resp_error   <= req_error;
        if (!req_error)
          data_memory_access_address <= {2'b00, req_addr[31:2]};
      end
      if (state == ACCESS && !lat_write)
        resp_rdata <= load_data;
      if (state == RMW_READ)
        merge_word <= data_memory_read_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a write-through word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;

  logic [31:0] mem [0:4095];

  int          n_checks = 0;
  int          n_fail = 0;
  int          lat;
  logic [31:0] r_rdata;
  logic        r_error;
  int          we_cycles;
  logic        we_at [1:8];
  logic [31:0] addr_at [1:8];
  logic [31:0] wd_at [1:8];
  logic        ready_at_resp;

  load_store_unit #(.MEM_WORDS(4096)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .data_memory_write_enable(dm_we),
    .data_memory_access_address(dm_addr), .data_memory_write_data(dm_wdata),
    .data_memory_read_data(dm_rdata)
  );

  always #5 clk = ~clk;

  assign dm_rdata = dm_we ? dm_wdata : ((dm_addr < 32'd4096) ? mem[dm_addr[11:0]] : 32'h0);

  always @(posedge clk)
    if (dm_we && dm_addr < 32'd4096) mem[dm_addr[11:0]] <= dm_wdata;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for acceptance, then follow it until resp_valid (bounded)
  task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] a, input logic [31:0] d);
    int n;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0; r_rdata = 32'hx; r_error = 1'bx; we_cycles = 0; ready_at_resp = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      we_at[k] = dm_we; addr_at[k] = dm_addr; wd_at[k] = dm_wdata;
      if (dm_we) we_cycles++;
      if (resp_valid) begin
        lat = k; r_rdata = resp_rdata; r_error = resp_error; ready_at_resp = req_ready;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_load(input string tag, input logic [1:0] sz, input logic u,
                            input logic [31:0] a, input logic [31:0] exp);
    apply_stimulus(1'b0, sz, u, a, 32'h0);
    check_output({tag, "_lat"}, 32'(lat), 32'd2);
    check_output({tag, "_data"}, r_rdata, exp);
    check_output({tag, "_err"}, {31'b0, r_error}, 32'd0);
    check_output({tag, "_we"}, 32'(we_cycles), 32'd0);
  endtask

  task automatic check_reject(input string tag, input logic w, input logic [1:0] sz,
                              input logic [31:0] a);
    apply_stimulus(w, sz, 1'b0, a, 32'hFFFF_FFFF);
    check_output({tag, "_lat"}, 32'(lat), 32'd1);
    check_output({tag, "_err"}, {31'b0, r_error}, 32'd1);
    check_output({tag, "_data"}, r_rdata, 32'h0);
    check_output({tag, "_we"}, 32'(we_cycles), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    #1;
    check_output("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check_output("rst_resp_error", {31'b0, resp_error}, 32'd0);
    check_output("rst_resp_rdata", resp_rdata, 32'h0);
    check_output("rst_we", {31'b0, dm_we}, 32'd0);
    check_output("rst_addr", dm_addr, 32'h0);
    check_output("rst_wdata", dm_wdata, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check_output("idle_ready", {31'b0, req_ready}, 32'd1);

    // sw 0xDEADBEEF -> 0x100
    apply_stimulus(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
    check_output("sw_lat", 32'(lat), 32'd2);
    check_output("sw_err", {31'b0, r_error}, 32'd0);
    check_output("sw_rdata", r_rdata, 32'h0);
    check_output("sw_we_cycles", 32'(we_cycles), 32'd1);
    check_output("sw_we_t1", {31'b0, we_at[1]}, 32'd1);
    check_output("sw_addr", addr_at[1], 32'h40);
    check_output("sw_wdata", wd_at[1], 32'hDEADBEEF);
    check_output("resp_ready_low", {31'b0, ready_at_resp}, 32'd0);

    check_load("lw_100", 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);

    // sb 0x12AA -> 0x101: read at T+1, write at T+2
    apply_stimulus(1'b1, 2'b00, 1'b0, 32'h101, 32'h000012AA);
    check_output("sb_lat", 32'(lat), 32'd3);
    check_output("sb_we_t1", {31'b0, we_at[1]}, 32'd0);
    check_output("sb_we_t2", {31'b0, we_at[2]}, 32'd1);
    check_output("sb_addr", addr_at[2], 32'h40);
    check_output("sb_wdata", wd_at[2], 32'hDEADAAEF);
    check_output("sb_err", {31'b0, r_error}, 32'd0);

    check_load("lb_101", 2'b00, 1'b0, 32'h101, 32'hFFFFFFAA);
    check_load("lbu_101", 2'b00, 1'b1, 32'h101, 32'h000000AA);
    check_load("lh_102", 2'b01, 1'b0, 32'h102, 32'hFFFFDEAD);
    check_load("lhu_102", 2'b01, 1'b1, 32'h102, 32'h0000DEAD);

`ifdef LSU_MISALIGN_TRAP_EN
    check_reject("lw_102_trap", 1'b0, 2'b10, 32'h102);
    check_reject("lh_103_trap", 1'b0, 2'b01, 32'h103);
`else
    check_load("lw_102_align", 2'b10, 1'b0, 32'h102, 32'hDEADAAEF);
    check_load("lh_103_align", 2'b01, 1'b0, 32'h103, 32'hFFFFDEAD);
`endif

    check_reject("sw_oor", 1'b1, 2'b10, 32'h4000);
    check_reject("size11", 1'b0, 2'b11, 32'h100);
    check_load("lbu_last_word", 2'b00, 1'b1, 32'h3FFF, 32'h0);

    // sh 0xBEEF -> 0x100 with reset during RMW_READ
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b01; req_unsigned = 1'b0;
    req_addr = 32'h100; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_output("rst_mid_we", {31'b0, dm_we}, 32'd0);
    check_output("rst_mid_valid", {31'b0, resp_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_output("rst_hold_we", {31'b0, dm_we}, 32'd0);
      check_output("rst_hold_valid", {31'b0, resp_valid}, 32'd0);
    end
    rst = 1'b0;
    #1;
    check_output("rst_rel_ready", {31'b0, req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check_output("rst_rel_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    check_output("rst_mem_intact", mem[12'h040], 32'hDEADAAEF);
    check_load("lw_after_rst", 2'b10, 1'b0, 32'h100, 32'hDEADAAEF);

    // sh to the upper half lane, upper wdata bits ignored
    apply_stimulus(1'b1, 2'b01, 1'b0, 32'h102, 32'hCAFEBEEF);
    check_output("sh_lat", 32'(lat), 32'd3);
    check_output("sh_we_t1", {31'b0, we_at[1]}, 32'd0);
    check_output("sh_wdata", wd_at[2], 32'hBEEFAAEF);
    check_load("lw_after_sh", 2'b10, 1'b0, 32'h100, 32'hBEEFAAEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
